vision_ctrl: RTL and testbench

VISION_CTRL -- requirements
Module: vision_ctrl

---
 rtl/vision_ctrl.sv | 141 ++++++++++++++
 tb/tb_vision_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vision_ctrl.sv
// Visual-acuity test sequencer: debounced keys drive a level ladder; passes 2 hits/level, fails on 2 misses.
// Outputs registered, 1-cycle latency from key pulse; no backpressure (keys are one-shot pulses).
module vision_ctrl #(
  parameter logic [19:0] DEB_CNT = 20'd200000,
  parameter logic [31:0] TIMEOUT = 32'd100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       key_ok_n,
  input  logic       key_fail_n,
  output logic [7:0] vision_bcd,
  output logic       ctr_signal,
  output logic [3:0] level_idx,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_TRIAL, S_DONE} state_t;

  logic [2:0] key_raw;
  logic [2:0] key_p;
  assign key_raw = {key_fail_n, key_ok_n, key_start_n};

  for (genvar k = 0; k < 3; k++) begin : g_deb
    logic        s1_q, s2_q, deb_q;
    logic [19:0] cnt_q;

    // rst_n is active-high here: 1 holds the block in reset
    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        s1_q  <= 1'b1;
        s2_q  <= 1'b1;
        deb_q <= 1'b1;
        cnt_q <= '0;
      end else begin
        s1_q <= key_raw[k];
        s2_q <= s1_q;
        if (s2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DEB_CNT - 20'd1) begin
          deb_q <= s2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 20'd1;
        end
      end
    end

    assign key_p[k] = !s2_q && deb_q && (cnt_q == DEB_CNT - 20'd1);
  end

  logic start_p, ok_p, fail_p;
  assign start_p = key_p[0];
  assign ok_p    = key_p[1];
  assign fail_p  = key_p[2];

  function automatic logic [7:0] lvl_bcd(input logic [3:0] i);
    logic [3:0] tenth;
    tenth = i + 4'd1;
    if (i <= 4'd8) return {tenth, 4'd0};
    case (i)
      4'd9:    return 8'h01;
      4'd10:   return 8'h21;
      default: return 8'h51;
    endcase
  endfunction

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [1:0]  hit_q, miss_q;
  logic [31:0] tmr_q;
  logic [7:0]  bcd_q;
  logic        ctr_q, done_q;

  logic ok_only, fail_only, tmo;
  assign ok_only   = ok_p & ~fail_p;
  assign fail_only = fail_p & ~ok_p;
  assign tmo       = (tmr_q == TIMEOUT - 32'd1);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      tmr_q   <= '0;
      bcd_q   <= 8'hFF;
      ctr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // start wins over any response, in every state
      if (start_p) begin
        state_q <= S_TRIAL;
        idx_q   <= '0;
        hit_q   <= '0;
        miss_q  <= '0;
        tmr_q   <= '0;
        bcd_q   <= lvl_bcd(4'd0);
        ctr_q   <= 1'b0;
      end else if (state_q == S_TRIAL) begin
        if (ok_only) begin
          tmr_q <= '0;
          if (hit_q == 2'd1) begin
            if (idx_q == 4'd11) begin
              state_q <= S_DONE;
              bcd_q   <= 8'h51;
              ctr_q   <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              idx_q  <= idx_q + 4'd1;
              hit_q  <= '0;
              miss_q <= '0;
              bcd_q  <= lvl_bcd(idx_q + 4'd1);
            end
          end else begin
            hit_q <= hit_q + 2'd1;
          end
        end else if (fail_only || tmo) begin
          tmr_q <= '0;
          if (miss_q == 2'd1) begin
            state_q <= S_DONE;
            bcd_q   <= (idx_q == 4'd0) ? 8'h00 : lvl_bcd(idx_q - 4'd1);
            ctr_q   <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            miss_q <= miss_q + 2'd1;
          end
        end else begin
          tmr_q <= tmr_q + 32'd1;
        end
      end
    end
  end

  assign vision_bcd = bcd_q;
  assign ctr_signal = ctr_q;
  assign level_idx  = idx_q;
  assign done       = done_q;

endmodule

// File: tb/tb_vision_ctrl.sv
// Directed bench for vision_ctrl with a scoreboard queue of expected output snapshots.
module tb_vision_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ks = 1'b1, ko = 1'b1, kf = 1'b1;
  logic [7:0] vision_bcd;
  logic       ctr_signal;
  logic [3:0] level_idx;
  logic       done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;

  typedef struct {
    logic [7:0] bcd;
    logic [3:0] idx;
    logic       ctr;
    string      tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  vision_ctrl #(.DEB_CNT(20'd4), .TIMEOUT(32'd100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_start_n(ks),
    .key_ok_n   (ko),
    .key_fail_n (kf),
    .vision_bcd (vision_bcd),
    .ctr_signal (ctr_signal),
    .level_idx  (level_idx),
    .done       (done)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [7:0] tbl(input int i);
    if (i < 9) return 8'((i + 1) << 4);
    if (i == 9) return 8'h01;
    if (i == 10) return 8'h21;
    return 8'h51;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input string tag, input logic [7:0] bcd, input logic [3:0] idx, input logic ctr);
    exp_t e;
    e.tag = tag; e.bcd = bcd; e.idx = idx; e.ctr = ctr;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, " bcd"}, {24'd0, vision_bcd}, {24'd0, e.bcd});
      chk({e.tag, " idx"}, {28'd0, level_idx}, {28'd0, e.idx});
      chk({e.tag, " ctr"}, {31'd0, ctr_signal}, {31'd0, e.ctr});
    end
  endtask

  // which: bit0 start, bit1 ok, bit2 fail
  task automatic press(input int which);
    @(negedge clk);
    if (which[0]) ks = 1'b0;
    if (which[1]) ko = 1'b0;
    if (which[2]) kf = 1'b0;
    cycles(10);
    ks = 1'b1; ko = 1'b1; kf = 1'b1;
    cycles(10);
  endtask

  task automatic act(input string tag, input int which, input logic [7:0] bcd, input logic [3:0] idx, input logic ctr);
    push_exp(tag, bcd, idx, ctr);
    press(which);
    pop_cmp();
  endtask

  task automatic check_done(input string tag);
    exp_done++;
    chk({tag, " done pulses"}, 32'(done_cnt), 32'(exp_done));
    chk({tag, " done low"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    // reset state
    cycles(3);
    chk("rst bcd", {24'd0, vision_bcd}, 32'hFF);
    chk("rst idx", {28'd0, level_idx}, 32'd0);
    chk("rst ctr", {31'd0, ctr_signal}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    rst_n = 1'b0;
    cycles(3);

    // key bounce: one ok pulse only
    act("bounce start", 1, 8'h10, 4'd0, 1'b0);
    push_exp("bounce hold", 8'h10, 4'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      ko = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    ko = 1'b0;
    cycles(10);
    pop_cmp();
    ko = 1'b1;
    cycles(10);
    act("bounce 2nd ok", 2, 8'h20, 4'd1, 1'b0);

    // restart from TRIAL, then full pass
    act("restart", 1, 8'h10, 4'd0, 1'b0);
    for (int l = 0; l < 12; l++) begin
      act($sformatf("pass L%0d ok1", l), 2, tbl(l), 4'(l), 1'b0);
      if (l < 11) act($sformatf("pass L%0d ok2", l), 2, tbl(l + 1), 4'(l + 1), 1'b0);
      else        act("pass L11 ok2", 2, 8'h51, 4'd11, 1'b1);
    end
    check_done("pass");

    // fail at level 5
    act("fail start", 1, 8'h10, 4'd0, 1'b0);
    for (int l = 0; l < 5; l++) begin
      act($sformatf("fail L%0d ok1", l), 2, tbl(l), 4'(l), 1'b0);
      act($sformatf("fail L%0d ok2", l), 2, tbl(l + 1), 4'(l + 1), 1'b0);
    end
    act("fail L5 ok", 2, 8'h60, 4'd5, 1'b0);
    act("fail L5 miss1", 4, 8'h60, 4'd5, 1'b0);
    act("fail L5 miss2", 4, 8'h50, 4'd5, 1'b1);
    check_done("fail");

    // timeout misses at level 0
    act("tmo start", 1, 8'h10, 4'd0, 1'b0);
    push_exp("tmo one miss", 8'h10, 4'd0, 1'b0);
    cycles(100);
    pop_cmp();
    push_exp("tmo two miss", 8'h00, 4'd0, 1'b1);
    cycles(100);
    pop_cmp();
    check_done("tmo");

    // simultaneous ok+fail ignored
    act("sim start", 1, 8'h10, 4'd0, 1'b0);
    act("sim L0 ok1", 2, 8'h10, 4'd0, 1'b0);
    act("sim L0 ok2", 2, 8'h20, 4'd1, 1'b0);
    act("sim L1 ok1", 2, 8'h20, 4'd1, 1'b0);
    act("sim L1 ok2", 2, 8'h30, 4'd2, 1'b0);
    act("sim both", 6, 8'h30, 4'd2, 1'b0);
    act("sim after ok1", 2, 8'h30, 4'd2, 1'b0);
    act("sim after ok2", 2, 8'h40, 4'd3, 1'b0);

    // climb to level 7 and reset mid-trial
    for (int l = 3; l < 7; l++) begin
      act($sformatf("rst L%0d ok1", l), 2, tbl(l), 4'(l), 1'b0);
      act($sformatf("rst L%0d ok2", l), 2, tbl(l + 1), 4'(l + 1), 1'b0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("midrst bcd", {24'd0, vision_bcd}, 32'hFF);
    chk("midrst idx", {28'd0, level_idx}, 32'd0);
    chk("midrst ctr", {31'd0, ctr_signal}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    cycles(3);
    rst_n = 1'b0;
    push_exp("idle wait", 8'hFF, 4'd0, 1'b0);
    cycles(20);
    pop_cmp();
    act("post rst start", 1, 8'h10, 4'd0, 1'b0);
    chk("done total", 32'(done_cnt), 32'(exp_done));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
